// File: rtl/dreg_alu_sequencer.sv
// dreg_alu_sequencer
// Sequences one register-to-register ALU operation Dn(dst) <= Dn(dst) OP Dn(src)
// for byte, word or long sizes. Long operations run as two 16-bit halves, with the
// carry/borrow from the low half chained into the high half.
//
// Optional feature: define FLAGS_EN to add the CCR[4:0] = {X,N,Z,V,C} output.
//
// Ports:
//   CLK, RESET            core clock (rising edge), asynchronous active-low reset
//   REQ, OP, SIZE,        command handshake from decode; REQ sampled only when idle
//   SRC, DST
//   BUSY, DONE            busy from acceptance through DONE; DONE pulses on write-back
//   RF_SEL_A/RF_RDATA_A   register file read port A (source)
//   RF_SEL_B/RF_RDATA_B   register file read port B and write port (destination)
//   RF_WE, RF_WDATA       register file write
//   ALU_A/B/OP/CIN        registered operands to the 16-bit ALU
//   ALU_OUT, ALU_COUT     ALU result, valid one cycle after operands are registered
//   CCR                   condition codes (FLAGS_EN only)
module dreg_alu_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic [1:0]  OP,
  input  logic [1:0]  SIZE,
  input  logic [2:0]  SRC,
  input  logic [2:0]  DST,
  output logic        BUSY,
  output logic        DONE,
  output logic [2:0]  RF_SEL_A,
  output logic [2:0]  RF_SEL_B,
  input  logic [31:0] RF_RDATA_A,
  input  logic [31:0] RF_RDATA_B,
  output logic        RF_WE,
  output logic [31:0] RF_WDATA,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [1:0]  ALU_OP,
  output logic        ALU_CIN,
  input  logic [15:0] ALU_OUT,
  input  logic        ALU_COUT
`ifdef FLAGS_EN
  ,
  output logic [4:0]  CCR
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoEx,
    StLoWb,
    StHiEx,
    StHiWb,
    StWrite
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  sel_a_q, sel_a_d;
  logic [2:0]  sel_b_q, sel_b_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic        alu_cin_q, alu_cin_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] dst_hi_q, dst_hi_d;
  logic [15:0] src_hi_q, src_hi_d;

  logic is_byte;
  logic is_long;
  logic is_arith;

  // Reserved size 11 falls through as word.
  assign is_byte  = (size_q == 2'b00);
  assign is_long  = (size_q == 2'b10);
  assign is_arith = ~op_q[1];

`ifdef FLAGS_EN
  logic       dmsb_q, dmsb_d;
  logic       smsb_q, smsb_d;
  logic       carry_q, carry_d;
  logic [4:0] ccr_q, ccr_d;
  logic       res_msb;
  logic       res_zero;
  logic       ovf;

  always_comb begin
    res_msb  = wdata_q[15];
    res_zero = (wdata_q[15:0] == 16'h0000);
    if (is_byte) begin
      res_msb  = wdata_q[7];
      res_zero = (wdata_q[7:0] == 8'h00);
    end else if (is_long) begin
      res_msb  = wdata_q[31];
      res_zero = (wdata_q == 32'h0000_0000);
    end
    // ADD overflows when like-signed operands give an opposite-signed result;
    // SUB (dst-src) when unlike-signed operands flip the sign of dst.
    if (op_q == 2'b00) begin
      ovf = (dmsb_q == smsb_q) && (res_msb != dmsb_q);
    end else begin
      ovf = (dmsb_q != smsb_q) && (res_msb != dmsb_q);
    end
  end

  assign CCR = ccr_q;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    size_d    = size_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    alu_cin_d = alu_cin_q;
    wdata_d   = wdata_q;
    dst_hi_d  = dst_hi_q;
    src_hi_d  = src_hi_q;
`ifdef FLAGS_EN
    dmsb_d    = dmsb_q;
    smsb_d    = smsb_q;
    carry_d   = carry_q;
    ccr_d     = ccr_q;
`endif

    case (state_q)
      StIdle: begin
        if (REQ) begin
          op_d    = OP;
          size_d  = SIZE;
          sel_a_d = SRC;
          sel_b_d = DST;
          state_d = StRead;
        end
      end
      StRead: begin
        // Preload with the old dst so bits above the operand size survive.
        wdata_d   = RF_RDATA_B;
        alu_op_d  = op_q;
        alu_cin_d = 1'b0;
        dst_hi_d  = RF_RDATA_B[31:16];
        src_hi_d  = RF_RDATA_A[31:16];
        if (is_byte) begin
          // Zero-extension puts the byte carry/borrow into ALU_OUT[8].
          alu_a_d = {8'h00, RF_RDATA_B[7:0]};
          alu_b_d = {8'h00, RF_RDATA_A[7:0]};
        end else begin
          alu_a_d = RF_RDATA_B[15:0];
          alu_b_d = RF_RDATA_A[15:0];
        end
`ifdef FLAGS_EN
        dmsb_d = is_byte ? RF_RDATA_B[7] : (is_long ? RF_RDATA_B[31] : RF_RDATA_B[15]);
        smsb_d = is_byte ? RF_RDATA_A[7] : (is_long ? RF_RDATA_A[31] : RF_RDATA_A[15]);
`endif
        state_d = StLoEx;
      end
      StLoEx: begin
        state_d = StLoWb;
      end
      StLoWb: begin
        if (is_byte) begin
          wdata_d[7:0] = ALU_OUT[7:0];
        end else begin
          wdata_d[15:0] = ALU_OUT;
        end
`ifdef FLAGS_EN
        carry_d = is_byte ? ALU_OUT[8] : ALU_COUT;
`endif
        if (is_long) begin
          alu_a_d   = dst_hi_q;
          alu_b_d   = src_hi_q;
          alu_cin_d = is_arith ? ALU_COUT : 1'b0;
          state_d   = StHiEx;
        end else begin
          state_d = StWrite;
        end
      end
      StHiEx: begin
        state_d = StHiWb;
      end
      StHiWb: begin
        wdata_d[31:16] = ALU_OUT;
`ifdef FLAGS_EN
        carry_d = ALU_COUT;
`endif
        state_d = StWrite;
      end
      StWrite: begin
`ifdef FLAGS_EN
        if (is_arith) begin
          ccr_d = {carry_q, res_msb, res_zero, ovf, carry_q};
        end else begin
          ccr_d = {ccr_q[4], res_msb, res_zero, 1'b0, 1'b0};
        end
`endif
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      op_q      <= 2'b00;
      size_q    <= 2'b00;
      sel_a_q   <= 3'd0;
      sel_b_q   <= 3'd0;
      alu_a_q   <= 16'h0000;
      alu_b_q   <= 16'h0000;
      alu_op_q  <= 2'b00;
      alu_cin_q <= 1'b0;
      wdata_q   <= 32'h0000_0000;
      dst_hi_q  <= 16'h0000;
      src_hi_q  <= 16'h0000;
`ifdef FLAGS_EN
      dmsb_q    <= 1'b0;
      smsb_q    <= 1'b0;
      carry_q   <= 1'b0;
      ccr_q     <= 5'd0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      size_q    <= size_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
      wdata_q   <= wdata_d;
      dst_hi_q  <= dst_hi_d;
      src_hi_q  <= src_hi_d;
`ifdef FLAGS_EN
      dmsb_q    <= dmsb_d;
      smsb_q    <= smsb_d;
      carry_q   <= carry_d;
      ccr_q     <= ccr_d;
`endif
    end
  end

  assign BUSY     = (state_q != StIdle);
  assign DONE     = (state_q == StWrite);
  assign RF_WE    = (state_q == StWrite);
  assign RF_SEL_A = sel_a_q;
  assign RF_SEL_B = sel_b_q;
  assign RF_WDATA = wdata_q;
  assign ALU_A    = alu_a_q;
  assign ALU_B    = alu_b_q;
  assign ALU_OP   = alu_op_q;
  assign ALU_CIN  = alu_cin_q;

endmodule

// File: doc/dreg_alu_sequencer.md
Name: dreg_alu_sequencer

Overview:
- Sequences one register-to-register ALU operation: Dn(dst) <= Dn(dst) OP Dn(src), size byte/word/long.
- Drives the data register file (2 combinational read ports, 1 write port) and the 16-bit registered ALU.
- Long operations run as two 16-bit halves with carry/borrow chained from the low half into the high half.
- Sits between instruction decode (REQ/DONE handshake) and the datapath; replaces hard-wired init/add states in the core.

Parameters:
- none (all widths fixed by the 68k datapath)

Ports:
- CLK  in  1  core clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- REQ  in  1  command valid; sampled only in IDLE
- OP  in  2  00 ADD, 01 SUB (dst-src), 10 AND, 11 OR
- SIZE  in  2  00 byte, 01 word, 10 long, 11 reserved (treated as word)
- SRC  in  3  source data register index
- DST  in  3  destination data register index
- BUSY  out  1  high from acceptance until DONE cycle inclusive
- DONE  out  1  one-cycle pulse coincident with the write-back
- RF_SEL_A  out  3  register file read port A select (source)
- RF_SEL_B  out  3  read port B / write port select (destination)
- RF_RDATA_A  in  32  port A read data, combinational from RF_SEL_A
- RF_RDATA_B  in  32  port B read data, combinational from RF_SEL_B
- RF_WE  out  1  write enable, register file writes RF_WDATA at rising edge
- RF_WDATA  out  32  write data
- ALU_A, ALU_B  out  16 each  registered ALU operands
- ALU_OP  out  2  same encoding as OP
- ALU_CIN  out  1  carry-in (ADD) / borrow-in (SUB); 0 for AND/OR
- ALU_OUT  in  16  ALU result, valid one cycle after operands registered
- ALU_COUT  in  1  carry/borrow out of bit 15, same timing as ALU_OUT

Behaviour:
- Reset (RESET low, async): state IDLE; BUSY, DONE, RF_WE, ALU_CIN = 0; RF_SEL_A/B, ALU_A/B, ALU_OP, RF_WDATA = 0. Reset mid-operation aborts; no write-back.
- IDLE: BUSY=0. REQ=1 at edge -> latch OP/SIZE/SRC/DST, RF_SEL_A<=SRC, RF_SEL_B<=DST -> READ. REQ ignored in all other states.
- READ: at edge RF_WDATA<=RF_RDATA_B (keeps untouched upper bits); ALU_A<=dst[15:0], ALU_B<=src[15:0], for byte zero-extended ({8'h00,x[7:0]}); ALU_OP<=OP; ALU_CIN<=0; dst/src [31:16] held internally -> LO_EX.
- LO_EX: ALU computing -> LO_WB.
- LO_WB: byte: RF_WDATA[7:0]<=ALU_OUT[7:0]; word/long: RF_WDATA[15:0]<=ALU_OUT. Long: ALU_A/B<=high halves, ALU_CIN<=ALU_COUT if OP ADD/SUB else 0 -> HI_EX; else -> WRITE.
- HI_EX -> HI_WB. HI_WB: RF_WDATA[31:16]<=ALU_OUT -> WRITE.
- WRITE: RF_WE=1, DONE=1, RF_SEL_B=DST for exactly this cycle -> IDLE.
- Latency: DONE in 4th cycle after accept edge (byte/word), 6th (long). Next REQ accepted earliest the cycle after DONE; the READ of a dependent command sees the new value.
- SRC==DST legal (Dn OP Dn). Byte leaves RF_WDATA[31:8] = old dst; word leaves [31:16].
- Arithmetic mod 2^size; carry out of byte = ALU_OUT[8] (zero-extension makes this exact for ADD and SUB).

Optional Feature:
- FLAGS_EN: adds output CCR[4:0] = {X,N,Z,V,C}, reset 0, updated only in WRITE cycle.
- N = msb of result at size; Z = result at size == 0; C = final carry/borrow (byte: ALU_OUT[8], else ALU_COUT of last half); V = signed overflow from operand/result msbs; X = C for ADD/SUB.
- AND/OR: V=C=0, X unchanged.
- Without FLAGS_EN: no CCR port, no flag logic.

Test Plan:
- D0=0x0000FFFF, D1=0x00000001, ADD long dst=D0 src=D1 -> D0=0x00010000, DONE at cycle 6, carry chained; FLAGS_EN: C=0, Z=0.
- D2=0x123456FF, D3=0x00000001, ADD byte dst=D2 -> D2=0x12345600, DONE at cycle 4; FLAGS_EN: Z=1, C=1, X=1.
- D4=0x00000000, D5=0x00000001, SUB long dst=D4 -> D4=0xFFFFFFFF; FLAGS_EN: N=1, C=1, V=0.
- D6=0xABCD7FFF, ADD word D6+D6 -> D6=0xABCDFFFE; FLAGS_EN: V=1, N=1, C=0.
- REQ held high through a long op and issued again the cycle after DONE -> second command accepted once, exactly one RF_WE pulse per command, second sees first's result.
- RESET low during HI_EX -> RF_WE never asserted, dst unchanged, BUSY=0 immediately; after release a new REQ completes normally.
